mcu_spi_target: RTL and testbench

MCU_SPI_TARGET -- requirements
Module: mcu_spi_target

---
 rtl/mcu_spi_target_if.sv | 32 +++
 rtl/mcu_spi_target.sv | 142 ++++++++++++++
 tb/tb_mcu_spi_target.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/mcu_spi_target_if.sv
// Signal bundle between the MCU SPI pins, the per-target command decoders and mcu_spi_target.
// The slave view is the SPI target itself; the master view is the MCU/decoder side.
interface mcu_spi_target_if;
    logic       spi_csn;
    logic       spi_sclk;
    logic       spi_mosi;
    logic       spi_miso;
    logic [7:0] sys_din;
    logic [7:0] hid_din;
    logic [7:0] osd_din;
    logic [7:0] sdc_din;
    logic [7:0] data_out;
    logic       data_start;
    logic       sys_strobe;
    logic       hid_strobe;
    logic       osd_strobe;
    logic       sdc_strobe;

    modport slave (
        input  spi_csn, spi_sclk, spi_mosi,
        input  sys_din, hid_din, osd_din, sdc_din,
        output spi_miso, data_out, data_start,
        output sys_strobe, hid_strobe, osd_strobe, sdc_strobe
    );

    modport master (
        output spi_csn, spi_sclk, spi_mosi,
        output sys_din, hid_din, osd_din, sdc_din,
        input  spi_miso, data_out, data_start,
        input  sys_strobe, hid_strobe, osd_strobe, sdc_strobe
    );
endinterface

// File: rtl/mcu_spi_target.sv
// MCU SPI (mode 0) target: byte 0 selects one of four command decoders, later bytes are
// strobed to it, and each decoder's reply is shifted back on MISO during the following byte.
module mcu_spi_target (
    input  logic            clk,
    input  logic            reset,
    mcu_spi_target_if.slave bus
);
    logic       r_csn_meta, r_csn_sync, r_csn_hist;
    logic       r_sclk_meta, r_sclk_sync, r_sclk_hist;
    logic       r_mosi_meta, r_mosi_sync;
    logic [1:0] r_fill;
    logic       r_armed;
    logic [6:0] r_rx;
    logic [2:0] r_bit_cnt;
    logic [1:0] r_byte_idx;
    logic [1:0] r_target;
    logic       r_invalid;
    logic [7:0] r_tx;
    logic       r_done;
    logic       r_ld;
    logic [7:0] r_data_out;
    logic       r_data_start;
    logic [3:0] r_strobe;

    logic       w_active, w_rise, w_fall, w_csn_rise, w_complete;
    logic [7:0] w_byte;
    logic [7:0] w_din;

    // Pin synchronizers; r_armed stays low after reset until csn has truly been sampled high,
    // so a transaction cut by reset cannot resume mid-stream.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_csn_meta  <= 1'b1;
            r_csn_sync  <= 1'b1;
            r_csn_hist  <= 1'b1;
            r_sclk_meta <= 1'b0;
            r_sclk_sync <= 1'b0;
            r_sclk_hist <= 1'b0;
            r_mosi_meta <= 1'b0;
            r_mosi_sync <= 1'b0;
            r_fill      <= 2'd0;
            r_armed     <= 1'b0;
        end else begin
            r_csn_meta  <= bus.spi_csn;
            r_csn_sync  <= r_csn_meta;
            r_csn_hist  <= r_csn_sync;
            r_sclk_meta <= bus.spi_sclk;
            r_sclk_sync <= r_sclk_meta;
            r_sclk_hist <= r_sclk_sync;
            r_mosi_meta <= bus.spi_mosi;
            r_mosi_sync <= r_mosi_meta;
            r_fill      <= (r_fill == 2'd2) ? r_fill : r_fill + 2'd1;
            r_armed     <= r_armed | ((r_fill == 2'd2) & r_csn_sync);
        end
    end

    // Edges are only honoured while csn_sync is low, so a coincident deassertion wins.
    assign w_active   = ~r_csn_sync & r_armed;
    assign w_rise     = w_active & r_sclk_sync & ~r_sclk_hist;
    assign w_fall     = w_active & ~r_sclk_sync & r_sclk_hist;
    assign w_csn_rise = r_csn_sync & ~r_csn_hist;
    assign w_byte     = {r_rx, r_mosi_sync};
    assign w_complete = w_rise & (r_bit_cnt == 3'd7);

    // Reply byte of the currently selected target.
    always_comb begin
        w_din = 8'h00;
        case (r_target)
            2'd0:    w_din = bus.sys_din;
            2'd1:    w_din = bus.hid_din;
            2'd2:    w_din = bus.osd_din;
            2'd3:    w_din = bus.sdc_din;
            default: w_din = 8'h00;
        endcase
    end

    // Byte assembly, target decode, strobe generation and the MISO shifter.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rx         <= 7'd0;
            r_bit_cnt    <= 3'd0;
            r_byte_idx   <= 2'd0;
            r_target     <= 2'd0;
            r_invalid    <= 1'b0;
            r_tx         <= 8'h00;
            r_done       <= 1'b0;
            r_ld         <= 1'b0;
            r_data_out   <= 8'h00;
            r_data_start <= 1'b0;
            r_strobe     <= 4'b0000;
        end else if (w_csn_rise) begin
            r_bit_cnt  <= 3'd0;
            r_byte_idx <= 2'd0;
            r_invalid  <= 1'b0;
            r_tx       <= 8'h00;
            r_done     <= 1'b0;
            r_ld       <= 1'b0;
            r_strobe   <= 4'b0000;
        end else begin
            r_strobe <= 4'b0000;
            r_done   <= w_complete;
            // The extra stage gives the decoder one clk after its strobe to present a reply.
            r_ld     <= r_done;
            if (w_rise) begin
                r_rx      <= w_byte[6:0];
                r_bit_cnt <= r_bit_cnt + 3'd1;
            end
            if (w_complete) begin
                if (r_byte_idx == 2'd0) begin
                    r_target  <= w_byte[1:0];
                    r_invalid <= (w_byte > 8'd3);
                end else if (!r_invalid) begin
                    r_data_out   <= w_byte;
                    r_data_start <= (r_byte_idx == 2'd1);
                    case (r_target)
                        2'd0:    r_strobe <= 4'b0001;
                        2'd1:    r_strobe <= 4'b0010;
                        2'd2:    r_strobe <= 4'b0100;
                        2'd3:    r_strobe <= 4'b1000;
                        default: r_strobe <= 4'b0000;
                    endcase
                end
                if (r_byte_idx != 2'd2) begin
                    r_byte_idx <= r_byte_idx + 2'd1;
                end
            end
            if (r_ld) begin
                r_tx <= r_invalid ? 8'h00 : w_din;
            end else if (w_fall && (r_bit_cnt != 3'd0)) begin
                r_tx <= {r_tx[6:0], 1'b0};
            end
        end
    end

    assign bus.spi_miso   = r_tx[7] & ~r_csn_sync;
    assign bus.data_out   = r_data_out;
    assign bus.data_start = r_data_start;
    assign bus.sys_strobe = r_strobe[0];
    assign bus.hid_strobe = r_strobe[1];
    assign bus.osd_strobe = r_strobe[2];
    assign bus.sdc_strobe = r_strobe[3];
endmodule

// File: tb/tb_mcu_spi_target.sv
// Directed bench for mcu_spi_target: drives SPI transactions as the MCU, models a sysctrl-like
// reply on sys_din and records every strobe with its data_out/data_start.
module tb_mcu_spi_target;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mcu_spi_target_if bus ();

    mcu_spi_target dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int vectors = 0;
    int miscompares = 0;

    logic [3:0] rec_stb [$];
    logic [7:0] rec_data [$];
    logic       rec_start [$];
    logic [3:0] w_stb;
    assign w_stb = {bus.sdc_strobe, bus.osd_strobe, bus.hid_strobe, bus.sys_strobe};

    // Strobe monitor, sampled on the inactive clock edge.
    always @(negedge clk) begin
        if (|w_stb) begin
            rec_stb.push_back(w_stb);
            rec_data.push_back(bus.data_out);
            rec_start.push_back(bus.data_start);
        end
    end

    // Sysctrl-like decoder: each strobe advances its reply through a fixed table.
    logic [7:0] sys_reply [4];
    logic [1:0] sys_cnt;
    logic [7:0] sys_init;
    logic       reply_reset;
    initial begin
        sys_reply[0] = 8'h5C;
        sys_reply[1] = 8'h42;
        sys_reply[2] = 8'h02;
        sys_reply[3] = 8'h00;
    end
    always @(posedge clk) begin
        if (bus.sys_strobe) begin
            bus.sys_din <= sys_reply[sys_cnt];
            sys_cnt     <= sys_cnt + 2'd1;
        end else if (reply_reset) begin
            bus.sys_din <= sys_init;
            sys_cnt     <= 2'd0;
        end
    end

    logic [7:0] tx_b [8];
    logic [7:0] miso_b [8];
    logic [7:0] junk;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic spi_bits(input logic [7:0] b, input int nbits, input int half,
                            output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            bus.spi_mosi = b[7-i];
            tick(half);
            rx = {rx[6:0], bus.spi_miso};
            bus.spi_sclk = 1'b1;
            tick(half);
            bus.spi_sclk = 1'b0;
        end
    endtask

    task automatic cs_low();
        bus.spi_csn = 1'b0;
        tick(4);
    endtask

    task automatic cs_high();
        tick(6);
        bus.spi_csn = 1'b1;
        tick(8);
    endtask

    task automatic xfer(input int n, input int half);
        cs_low();
        for (int k = 0; k < n; k++) begin
            spi_bits(tx_b[k], 8, half, miso_b[k]);
        end
        cs_high();
    endtask

    task automatic clear_rec();
        rec_stb.delete();
        rec_data.delete();
        rec_start.delete();
    endtask

    task automatic set_sys_reply(input logic [7:0] init);
        sys_init    = init;
        reply_reset = 1'b1;
        tick(1);
        reply_reset = 1'b0;
        tick(1);
    endtask

    initial begin
        reset        = 1'b1;
        bus.spi_csn  = 1'b1;
        bus.spi_sclk = 1'b0;
        bus.spi_mosi = 1'b0;
        bus.hid_din  = 8'hA5;
        bus.osd_din  = 8'h66;
        bus.sdc_din  = 8'hA5;
        reply_reset  = 1'b0;
        sys_init     = 8'h3C;
        reply_reset  = 1'b1;
        tick(3);
        reply_reset  = 1'b0;
        check("rst_strobes", {28'd0, w_stb}, 32'h0);
        check("rst_data_out", {24'd0, bus.data_out}, 32'h00);
        check("rst_data_start", {31'd0, bus.data_start}, 32'h0);
        check("rst_miso", {31'd0, bus.spi_miso}, 32'h0);
        reset = 1'b0;
        tick(4);

        // sys target, payload 00 AA BB CC with table-driven replies
        set_sys_reply(8'h3C);
        clear_rec();
        tx_b[0] = 8'h00; tx_b[1] = 8'h00; tx_b[2] = 8'hAA; tx_b[3] = 8'hBB; tx_b[4] = 8'hCC;
        xfer(5, 4);
        check("sys_count", rec_stb.size(), 32'd4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("sys_tgt%0d", i), {28'd0, rec_stb[i]}, 32'h1);
            check($sformatf("sys_data%0d", i), {24'd0, rec_data[i]}, {24'd0, tx_b[i+1]});
            check($sformatf("sys_start%0d", i), {31'd0, rec_start[i]}, (i == 0) ? 32'd1 : 32'd0);
        end
        check("sys_miso0", {24'd0, miso_b[0]}, 32'h00);
        check("sys_miso1", {24'd0, miso_b[1]}, 32'h3C);
        check("sys_miso2", {24'd0, miso_b[2]}, 32'h5C);
        check("sys_miso3", {24'd0, miso_b[3]}, 32'h42);
        check("sys_miso4", {24'd0, miso_b[4]}, 32'h02);
        check("hold_data_out", {24'd0, bus.data_out}, 32'hCC);
        check("hold_data_start", {31'd0, bus.data_start}, 32'h0);

        // osd target
        clear_rec();
        tx_b[0] = 8'h02; tx_b[1] = 8'h07; tx_b[2] = 8'h11;
        xfer(3, 4);
        check("osd_count", rec_stb.size(), 32'd2);
        check("osd_tgt0", {28'd0, rec_stb[0]}, 32'h4);
        check("osd_tgt1", {28'd0, rec_stb[1]}, 32'h4);
        check("osd_data0", {24'd0, rec_data[0]}, 32'h07);
        check("osd_start0", {31'd0, rec_start[0]}, 32'h1);
        check("osd_data1", {24'd0, rec_data[1]}, 32'h11);
        check("osd_start1", {31'd0, rec_start[1]}, 32'h0);
        check("osd_miso1", {24'd0, miso_b[1]}, 32'h66);
        check("osd_miso2", {24'd0, miso_b[2]}, 32'h66);

        // invalid target select
        clear_rec();
        tx_b[0] = 8'h09; tx_b[1] = 8'h01; tx_b[2] = 8'h02;
        xfer(3, 4);
        check("inv_count", rec_stb.size(), 32'd0);
        check("inv_miso1", {24'd0, miso_b[1]}, 32'h00);
        check("inv_miso2", {24'd0, miso_b[2]}, 32'h00);

        // partial byte discarded, then a clean hid transaction
        clear_rec();
        cs_low();
        spi_bits(8'h01, 8, 4, junk);
        spi_bits(8'hFF, 5, 4, junk);
        cs_high();
        check("part_count", rec_stb.size(), 32'd0);
        tx_b[0] = 8'h01; tx_b[1] = 8'h33;
        xfer(2, 4);
        check("hid_count", rec_stb.size(), 32'd1);
        check("hid_tgt", {28'd0, rec_stb[0]}, 32'h2);
        check("hid_data", {24'd0, rec_data[0]}, 32'h33);
        check("hid_start", {31'd0, rec_start[0]}, 32'h1);
        check("hid_miso1", {24'd0, miso_b[1]}, 32'hA5);

        // reset mid-transaction with csn held low
        clear_rec();
        cs_low();
        spi_bits(8'h00, 8, 4, junk);
        spi_bits(8'h55, 8, 4, junk);
        spi_bits(8'h77, 3, 4, junk);
        check("pre_rst_count", rec_stb.size(), 32'd1);
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        check("mid_rst_data_out", {24'd0, bus.data_out}, 32'h00);
        clear_rec();
        tick(4);
        spi_bits(8'h00, 8, 4, junk);
        spi_bits(8'h44, 8, 4, junk);
        cs_high();
        check("post_rst_quiet", rec_stb.size(), 32'd0);
        tx_b[0] = 8'h00; tx_b[1] = 8'h44;
        xfer(2, 4);
        check("rearm_count", rec_stb.size(), 32'd1);
        check("rearm_tgt", {28'd0, rec_stb[0]}, 32'h1);
        check("rearm_data", {24'd0, rec_data[0]}, 32'h44);
        check("rearm_start", {31'd0, rec_start[0]}, 32'h1);

        // random payloads at f_clk/8 and f_clk/16
        for (int h = 4; h <= 8; h += 4) begin
            clear_rec();
            tx_b[0] = 8'h01;
            for (int i = 1; i < 7; i++) tx_b[i] = 8'($urandom);
            xfer(7, h);
            check($sformatf("rnd%0d_count", h), rec_stb.size(), 32'd6);
            for (int i = 0; i < 6; i++) begin
                check($sformatf("rnd%0d_data%0d", h, i), {24'd0, rec_data[i]}, {24'd0, tx_b[i+1]});
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
